// File: rtl/store_buffer_param.sv
// store_buffer_param: N-entry store buffer between the memory stage and the
// data cache. Retiring stores are queued in a circular FIFO and drained in
// order through a valid/ack handshake. Younger loads are forwarded from the
// youngest relevant entry. A stall is raised when the buffer is full, when a
// word load hits a byte entry, or while a fence waits for the buffer to empty.
//
// Optional build macro: STORE_BUFFER_COALESCE_EN
//   When defined, a store may merge into the youngest entry if that entry
//   holds the same word address. When undefined, every store allocates.
module store_buffer_param #(
    parameter int WORD_SIZE = 32,
    parameter int ADDR_W    = 32,
    parameter int DEPTH     = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       st_valid,
    input  logic [ADDR_W-1:0]          st_addr,
    input  logic [WORD_SIZE-1:0]       st_data,
    input  logic                       st_byte,
    input  logic                       ld_valid,
    input  logic [ADDR_W-1:0]          ld_addr,
    input  logic                       ld_byte,
    input  logic                       fence_req,
    output logic                       drain_valid,
    output logic [ADDR_W-1:0]          drain_addr,
    output logic [WORD_SIZE-1:0]       drain_data,
    output logic                       drain_byte,
    input  logic                       drain_ack,
    output logic                       fwd_hit,
    output logic [WORD_SIZE-1:0]       fwd_data,
    output logic                       sb_stall,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    // Entry storage
    logic [ADDR_W-1:0]    addr_r [DEPTH];
    logic [WORD_SIZE-1:0] data_r [DEPTH];
    logic [DEPTH-1:0]     byte_r;

    logic [PTR_W-1:0] head_r;
    logic [PTR_W-1:0] tail_r;
    logic [CNT_W-1:0] count_r;

    logic [PTR_W-1:0] young_s;
    logic             full_s;
    logic             empty_s;
    logic             merge_s;
    logic             alloc_s;
    logic             deq_s;
    logic             hit_s;
    logic             conflict_s;
    logic [WORD_SIZE-1:0] fwd_word_s;
    logic [PTR_W-1:0] idx_s;

    // Little-endian byte lane extraction from a buffered word
    function automatic logic [7:0] lane_of(input logic [WORD_SIZE-1:0] word,
                                           input logic [1:0] lane);
        logic [7:0] res;
        case (lane)
            2'd0:    res = word[7:0];
            2'd1:    res = word[15:8];
            2'd2:    res = word[23:16];
            2'd3:    res = word[31:24];
            default: res = 8'h00;
        endcase
        return res;
    endfunction

    assign young_s = tail_r - PTR_W'(1);
    assign full_s  = (count_r == CNT_W'(DEPTH));
    assign empty_s = (count_r == CNT_W'(0));
    assign deq_s   = !empty_s && drain_ack;
    // Capacity is judged on the start-of-cycle count, so a same-cycle drain never frees room
    assign alloc_s = st_valid && !merge_s && !full_s;

`ifdef STORE_BUFFER_COALESCE_EN
    // Decide whether the incoming store folds into the youngest entry
    always_comb begin
        merge_s = 1'b0;
        if (st_valid && !empty_s
            && (addr_r[young_s][ADDR_W-1:2] == st_addr[ADDR_W-1:2])
            && (!st_byte || !byte_r[young_s] || (addr_r[young_s][1:0] == st_addr[1:0]))
            && !((young_s == head_r) && drain_ack)) begin
            merge_s = 1'b1;
        end else begin
            merge_s = 1'b0;
        end
    end
`else
    assign merge_s = 1'b0;
`endif

    // Pointer, occupancy and entry updates; reset discards all entries at once
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_r  <= '0;
            tail_r  <= '0;
            count_r <= '0;
            byte_r  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                addr_r[i] <= '0;
                data_r[i] <= '0;
            end
        end else begin
            if (alloc_s) begin
                addr_r[tail_r] <= st_addr;
                data_r[tail_r] <= st_data;
                byte_r[tail_r] <= st_byte;
                tail_r         <= tail_r + PTR_W'(1);
            end
            if (merge_s) begin
                if (!st_byte) begin
                    addr_r[young_s] <= st_addr;
                    data_r[young_s] <= st_data;
                    byte_r[young_s] <= 1'b0;
                end else if (!byte_r[young_s]) begin
                    data_r[young_s][{st_addr[1:0], 3'b000} +: 8] <= st_data[7:0];
                end else begin
                    data_r[young_s] <= st_data;
                end
            end
            if (deq_s) begin
                head_r <= head_r + PTR_W'(1);
            end
            case ({alloc_s, deq_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Forwarding search: walk oldest to youngest so the youngest relevant entry wins
    always_comb begin
        hit_s      = 1'b0;
        conflict_s = 1'b0;
        fwd_word_s = '0;
        idx_s      = head_r;
        for (int i = 0; i < DEPTH; i++) begin
            idx_s = head_r + PTR_W'(i);
            if (ld_valid && (CNT_W'(i) < count_r)
                && (addr_r[idx_s][ADDR_W-1:2] == ld_addr[ADDR_W-1:2])) begin
                if (byte_r[idx_s] && ld_byte && (addr_r[idx_s][1:0] != ld_addr[1:0])) begin
                    // other byte lane: leaves the older result in place
                    hit_s = hit_s;
                end else if (byte_r[idx_s] && !ld_byte) begin
                    hit_s      = 1'b0;
                    conflict_s = 1'b1;
                    fwd_word_s = '0;
                end else if (!ld_byte) begin
                    hit_s      = 1'b1;
                    conflict_s = 1'b0;
                    fwd_word_s = data_r[idx_s];
                end else if (byte_r[idx_s]) begin
                    hit_s      = 1'b1;
                    conflict_s = 1'b0;
                    fwd_word_s = {{(WORD_SIZE-8){1'b0}}, data_r[idx_s][7:0]};
                end else begin
                    hit_s      = 1'b1;
                    conflict_s = 1'b0;
                    fwd_word_s = {{(WORD_SIZE-8){1'b0}}, lane_of(data_r[idx_s], ld_addr[1:0])};
                end
            end else begin
                hit_s = hit_s;
            end
        end
    end

    assign drain_valid = !empty_s;
    assign drain_addr  = addr_r[head_r];
    assign drain_data  = data_r[head_r];
    assign drain_byte  = byte_r[head_r];
    assign fwd_hit     = hit_s;
    assign fwd_data    = fwd_word_s;
    assign sb_stall    = (st_valid && full_s && !merge_s) || conflict_s || (fence_req && !empty_s);
    assign full        = full_s;
    assign empty       = empty_s;
    assign count       = count_r;

endmodule

// File: tb/tb_store_buffer_param.sv
// Self-checking bench for store_buffer_param: directed scenarios plus a
// randomized phase, all compared against a queue-based reference model.
module tb_store_buffer_param;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        st_valid, st_byte, ld_valid, ld_byte, fence_req, drain_ack;
    logic [31:0] st_addr, st_data, ld_addr;
    logic        drain_valid, drain_byte, fwd_hit, sb_stall, full, empty;
    logic [31:0] drain_addr, drain_data, fwd_data;
    logic [2:0]  count;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic        b;
    } ent_t;

    ent_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    store_buffer_param #(.WORD_SIZE(32), .ADDR_W(32), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data), .st_byte(st_byte),
        .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_byte(ld_byte),
        .fence_req(fence_req),
        .drain_valid(drain_valid), .drain_addr(drain_addr), .drain_data(drain_data),
        .drain_byte(drain_byte), .drain_ack(drain_ack),
        .fwd_hit(fwd_hit), .fwd_data(fwd_data), .sb_stall(sb_stall),
        .full(full), .empty(empty), .count(count)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // Store merge decision from the buffer rules (never when disabled)
    function automatic logic model_merge();
`ifdef STORE_BUFFER_COALESCE_EN
        ent_t y;
        if (!st_valid || q.size() == 0) return 1'b0;
        y = q[q.size()-1];
        if (y.addr[31:2] != st_addr[31:2]) return 1'b0;
        if (st_byte && y.b && (y.addr[1:0] != st_addr[1:0])) return 1'b0;
        if (q.size() == 1 && drain_ack) return 1'b0;
        return 1'b1;
`else
        return 1'b0;
`endif
    endfunction

    // Forwarding result: scan from youngest, skip irrelevant byte lanes
    task automatic model_fwd(output logic hit, output logic conf, output logic [31:0] d);
        hit = 1'b0; conf = 1'b0; d = 32'h0;
        if (ld_valid) begin
            for (int i = q.size() - 1; i >= 0; i--) begin
                if (q[i].addr[31:2] != ld_addr[31:2]) continue;
                if (q[i].b && ld_byte && (q[i].addr[1:0] != ld_addr[1:0])) continue;
                if (q[i].b && !ld_byte) begin
                    conf = 1'b1;
                    break;
                end
                hit = 1'b1;
                if (!ld_byte)      d = q[i].data;
                else if (q[i].b)   d = {24'h0, q[i].data[7:0]};
                else               d = (q[i].data >> {ld_addr[1:0], 3'b000}) & 32'hFF;
                break;
            end
        end
    endtask

    task automatic set_in(input logic sv, input logic [31:0] sa, input logic [31:0] sd,
                          input logic sb, input logic lv, input logic [31:0] la,
                          input logic lb, input logic f, input logic a);
        st_valid = sv; st_addr = sa; st_data = sd; st_byte = sb;
        ld_valid = lv; ld_addr = la; ld_byte = lb; fence_req = f; drain_ack = a;
    endtask

    task automatic sample();
        logic        h, c, st_exp;
        logic [31:0] d;
        @(negedge clk);
        model_fwd(h, c, d);
        st_exp = (st_valid && q.size() == DEPTH && !model_merge()) || c
                 || (fence_req && q.size() != 0);
        check_val("count", 32'(count), q.size());
        check_val("full", 32'(full), 32'(q.size() == DEPTH));
        check_val("empty", 32'(empty), 32'(q.size() == 0));
        check_val("drain_valid", 32'(drain_valid), 32'(q.size() != 0));
        if (q.size() != 0) begin
            check_val("drain_addr", drain_addr, q[0].addr);
            check_val("drain_data", drain_data, q[0].data);
            check_val("drain_byte", 32'(drain_byte), 32'(q[0].b));
        end
        check_val("fwd_hit", 32'(fwd_hit), 32'(h));
        check_val("fwd_data", fwd_data, d);
        check_val("sb_stall", 32'(sb_stall), 32'(st_exp));
    endtask

    task automatic edge_update();
        logic m, dq, fl;
        ent_t y;
        @(posedge clk);
        if (!rst) begin
            q.delete();
        end else begin
            m  = model_merge();
            dq = (q.size() != 0) && drain_ack;
            fl = (q.size() == DEPTH);
            if (m) begin
                y = q[q.size()-1];
                if (!st_byte) begin
                    y.addr = st_addr; y.data = st_data; y.b = 1'b0;
                end else if (!y.b) begin
                    y.data[{st_addr[1:0], 3'b000} +: 8] = st_data[7:0];
                end else begin
                    y.data = st_data;
                end
                q[q.size()-1] = y;
            end else if (st_valid && !fl) begin
                q.push_back('{addr: st_addr, data: st_data, b: st_byte});
            end
            if (dq) void'(q.pop_front());
        end
        #1;
    endtask

    task automatic cycle(input logic sv, input logic [31:0] sa, input logic [31:0] sd,
                         input logic sb, input logic lv, input logic [31:0] la,
                         input logic lb, input logic f, input logic a);
        set_in(sv, sa, sd, sb, lv, la, lb, f, a);
        sample();
        edge_update();
    endtask

    task automatic drain_all();
        for (int k = 0; k < 40 && q.size() != 0; k++) begin
            cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        end
        set_in(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        sample();
        check_val("drained", 32'(empty), 32'd1);
        edge_update();
    endtask

    initial begin
        set_in(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        #2;
        check_val("rst_drain_valid", 32'(drain_valid), 32'd0);
        check_val("rst_fwd_hit", 32'(fwd_hit), 32'd0);
        check_val("rst_fwd_data", fwd_data, 32'd0);
        check_val("rst_sb_stall", 32'(sb_stall), 32'd0);
        check_val("rst_full", 32'(full), 32'd0);
        check_val("rst_empty", 32'(empty), 32'd1);
        check_val("rst_count", 32'(count), 32'd0);
        #6 rst = 1'b1;
        @(posedge clk); #1;

        // Fill to capacity, then a store with a same-cycle ack is still refused
        for (int i = 0; i < 4; i++)
            cycle(1'b1, 32'h1000 + 32'(i * 4), $urandom, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        set_in(1'b1, 32'h2000, 32'h12345678, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        sample();
        check_val("full_flag", 32'(full), 32'd1);
        check_val("full_stall", 32'(sb_stall), 32'd1);
        check_val("full_count", 32'(count), 32'd4);
        edge_update();
        set_in(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        sample();
        check_val("count_after_ack", 32'(count), 32'd3);
        edge_update();
        drain_all();

        // Word entry forwarded to a byte load
        cycle(1'b1, 32'h100, 32'hAABBCCDD, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        set_in(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h102, 1'b1, 1'b0, 1'b0);
        sample();
        check_val("fwd_lane_hit", 32'(fwd_hit), 32'd1);
        check_val("fwd_lane_data", fwd_data, 32'h000000BB);
        edge_update();
        drain_all();

        // Byte entry against a word load: stall until it drains
        cycle(1'b1, 32'h201, 32'h5A, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        set_in(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h200, 1'b0, 1'b0, 1'b0);
        sample();
        check_val("conf_hit", 32'(fwd_hit), 32'd0);
        check_val("conf_stall", 32'(sb_stall), 32'd1);
        edge_update();
        set_in(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h200, 1'b0, 1'b0, 1'b1);
        sample();
        check_val("conf_stall_ack", 32'(sb_stall), 32'd1);
        edge_update();
        set_in(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h200, 1'b0, 1'b0, 1'b0);
        sample();
        check_val("conf_cleared", 32'(sb_stall), 32'd0);
        edge_update();

        // Youngest store wins; drain order depends on coalescing
        cycle(1'b1, 32'h10, 32'h1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 32'h10, 32'h2, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        set_in(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h10, 1'b0, 1'b0, 1'b0);
        sample();
        check_val("young_hit", 32'(fwd_hit), 32'd1);
        check_val("young_data", fwd_data, 32'h2);
        edge_update();
        set_in(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        sample();
`ifdef STORE_BUFFER_COALESCE_EN
        check_val("order_first", drain_data, 32'h2);
        check_val("order_count", 32'(count), 32'd1);
        edge_update();
`else
        check_val("order_first", drain_data, 32'h1);
        check_val("order_count", 32'(count), 32'd2);
        edge_update();
        sample();
        check_val("order_second", drain_data, 32'h2);
        edge_update();
`endif
        drain_all();

        // Fence waits for two drains; fence on an empty buffer does not stall
        cycle(1'b1, 32'h300, 32'hA, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 32'h304, 32'hB, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        set_in(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
        sample();
        check_val("fence_stall0", 32'(sb_stall), 32'd1);
        edge_update();
        sample();
        check_val("fence_stall1", 32'(sb_stall), 32'd1);
        edge_update();
        sample();
        check_val("fence_done", 32'(sb_stall), 32'd0);
        edge_update();
        set_in(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        sample();
        check_val("fence_empty", 32'(sb_stall), 32'd0);
        edge_update();

        // Asynchronous reset while draining three entries
        for (int i = 0; i < 3; i++)
            cycle(1'b1, 32'h400 + 32'(i * 4), $urandom, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        set_in(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        sample();
        #2 rst = 1'b0;
        q.delete();
        #1;
        check_val("arst_empty", 32'(empty), 32'd1);
        check_val("arst_count", 32'(count), 32'd0);
        check_val("arst_drain_valid", 32'(drain_valid), 32'd0);
        edge_update();
        rst = 1'b1;
        for (int i = 0; i < 3; i++)
            cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);

        // Randomized traffic over a small address window
        for (int n = 0; n < 600; n++) begin
            cycle(1'($urandom_range(0, 1)),
                  32'h500 + ($urandom_range(0, 3) << 2) + $urandom_range(0, 3),
                  $urandom,
                  1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)),
                  32'h500 + ($urandom_range(0, 3) << 2) + $urandom_range(0, 3),
                  1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 7) == 0),
                  1'($urandom_range(0, 2) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
